// File: rtl/ret_addr_stack_pkg.sv
// Shared sizing and checkpoint record for the speculative return-address stack.
// The top and checkpoint RAM take their default parameters from here.
package ret_addr_stack_pkg;
  localparam int RAS_DEPTH    = 16;
  localparam int RAS_IP_WIDTH = 48;
  localparam int RAS_TAG_W    = 4;
  localparam int RAS_SP_W     = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W    = RAS_SP_W + 1;

  typedef struct packed {
    logic [RAS_SP_W-1:0]     sp;
    logic [RAS_CNT_W-1:0]    cnt;
    logic [RAS_IP_WIDTH-1:0] tos;
  } ras_ckpt_t;
endpackage

// File: rtl/ret_addr_stack_ckpt_ram.sv
// Per-jump-tag snapshot table: one write port, combinational read so a
// restore sees the slot contents from before any same-cycle write.
module ras_ckpt_ram
  import ret_addr_stack_pkg::*;
#(
  parameter int TAG_W = RAS_TAG_W
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [TAG_W-1:0] waddr_i,
  input  ras_ckpt_t        wdata_i,
  input  logic [TAG_W-1:0] raddr_i,
  output ras_ckpt_t        rdata_o
);

  ras_ckpt_t mem_q [2**TAG_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Speculative return-address stack with per-jump checkpoints; a pop presents
// its predicted target one cycle later. Flush beats restore beats decode.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int DEPTH    = RAS_DEPTH,
  parameter int IP_WIDTH = RAS_IP_WIDTH,
  parameter int TAG_W    = RAS_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_en,
  input  logic                in_push,
  input  logic                in_pop,
  input  logic                in_isJump,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [IP_WIDTH-1:0] in_ret_addr,
  input  logic                restore_en,
  input  logic [TAG_W-1:0]    restore_tag,
  input  logic                flush,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] out_addr,
  output logic                out_underflow
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;

  logic [IP_WIDTH-1:0] stk_q [DEPTH];
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                unf_q, unf_d;
  logic [IP_WIDTH-1:0] addr_q, addr_d;

  logic                stk_we;
  logic [SP_W-1:0]     stk_waddr;
  logic [IP_WIDTH-1:0] stk_wdata;
  logic                ck_we;
  ras_ckpt_t           ck_wdata;
  ras_ckpt_t           ck_rdata;
  logic                empty;

  assign empty    = (cnt_q == '0);
  assign ck_wdata = '{sp: sp_q, cnt: cnt_q, tos: stk_q[sp_q]};

  ras_ckpt_ram #(
    .TAG_W (TAG_W)
  ) u_ckpt (
    .clk     (clk),
    .we_i    (ck_we),
    .waddr_i (in_tag),
    .wdata_i (ck_wdata),
    .raddr_i (restore_tag),
    .rdata_o (ck_rdata)
  );

  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    unf_d     = 1'b0;
    addr_d    = addr_q;
    stk_we    = 1'b0;
    stk_waddr = sp_q;
    stk_wdata = in_ret_addr;
    ck_we     = 1'b0;
    if (flush) begin
      sp_d  = '0;
      cnt_d = '0;
    end else if (restore_en) begin
      sp_d      = ck_rdata.sp;
      cnt_d     = ck_rdata.cnt;
      stk_we    = 1'b1;
      stk_waddr = ck_rdata.sp;
      stk_wdata = ck_rdata.tos;
    end else if (in_en) begin
      ck_we = in_isJump;
      if (in_pop) begin
        if (!empty) begin
          valid_d = 1'b1;
          addr_d  = stk_q[sp_q];
        end else begin
          unf_d = 1'b1;
        end
      end
      // Push+pop replaces the top in place; an empty stack gains one entry.
      if (in_push && in_pop) begin
        stk_we = 1'b1;
        if (empty) begin
          cnt_d = CNT_W'(1);
        end
      end else if (in_push) begin
        sp_d      = sp_q + 1'b1;
        stk_we    = 1'b1;
        stk_waddr = sp_q + 1'b1;
        if (cnt_q != CNT_W'(DEPTH)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (in_pop && !empty) begin
        sp_d  = sp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      unf_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      unf_q   <= unf_d;
      addr_q  <= addr_d;
    end
  end

  // Stack contents survive reset and flush; only the pointer and count clear.
  always_ff @(posedge clk) begin
    if (stk_we) begin
      stk_q[stk_waddr] <= stk_wdata;
    end
  end

  assign out_valid     = valid_q;
  assign out_addr      = addr_q;
  assign out_underflow = unf_q;

endmodule
